rf_wport_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback slot;
  - the out-of-order long-latency result channel (divider / uncached-load return).
- Pipeline writes have priority. Long-latency results are held in a small FIFO and drained into idle write slots.
- A starvation counter forces a pipeline stall request so a pending result cannot wait forever.
- Sits between the writeback stage and the regfile. Drives the regfile write port, the debug trace port and the stall request to control.

---
 rtl/rf_wport_arbiter_if.sv | 53 +++++
 rtl/rf_wport_arbiter.sv | 143 ++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_arbiter_if.sv
// Bundles the writeback, long-latency result, decode lookup and regfile/trace signals of the write-port arbiter.
// Pure wiring with no state; the latency is whatever the attached arbiter adds.
// Backpressure travels on lr_ready_o (result channel) and wb_stallreq_o (pipeline).
interface rf_wport_arbiter_if;
    // pipeline writeback slot
    logic        wb_flush_i;
    logic [3:0]  wb_wren_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic [31:0] wb_pc_i;
    // long-latency result channel
    logic        lr_valid_i;
    logic        lr_ready_o;
    logic [3:0]  lr_wren_i;
    logic [4:0]  lr_waddr_i;
    logic [31:0] lr_wdata_i;
    logic [31:0] lr_pc_i;
    // decode interlock lookup
    logic [4:0]  id_raddr1_i;
    logic [4:0]  id_raddr2_i;
    logic        pend_hit1_o;
    logic        pend_hit2_o;
    // regfile write port and control
    logic [3:0]  rf_wren_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        wb_stallreq_o;
    // trace port
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    // arbiter side
    modport slave (
        input  wb_flush_i, wb_wren_i, wb_waddr_i, wb_wdata_i, wb_pc_i,
        input  lr_valid_i, lr_wren_i, lr_waddr_i, lr_wdata_i, lr_pc_i,
        input  id_raddr1_i, id_raddr2_i,
        output lr_ready_o, pend_hit1_o, pend_hit2_o,
        output rf_wren_o, rf_waddr_o, rf_wdata_o, wb_stallreq_o,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    // pipeline / result-source / regfile side
    modport master (
        output wb_flush_i, wb_wren_i, wb_waddr_i, wb_wdata_i, wb_pc_i,
        output lr_valid_i, lr_wren_i, lr_waddr_i, lr_wdata_i, lr_pc_i,
        output id_raddr1_i, id_raddr2_i,
        input  lr_ready_o, pend_hit1_o, pend_hit2_o,
        input  rf_wren_o, rf_waddr_o, rf_wdata_o, wb_stallreq_o,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port: pipeline writes first, long-latency results queue in a FIFO and fill idle slots.
// Grant is combinational (0 cycles); a queued result writes no earlier than the cycle after it is pushed.
// lr_ready_o drops when the FIFO is full; a starving FIFO head raises a one-cycle registered stall request.
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,   // active-high despite the name: 1 holds the block in reset
    rf_wport_arbiter_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [3:0]  wren;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } ent_t;

    ent_t          r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_age;
    logic          r_stall;

    ent_t       w_pipe;
    ent_t       w_in;
    ent_t       w_head;
    ent_t       w_grant;
    logic       w_pipe_req;
    logic       w_fifo_req;
    logic       w_pop;
    logic       w_push;
    logic       w_ready;
    logic [3:0] w_age_nxt;
    logic       w_hit1;
    logic       w_hit2;

    // An entry blocks a decode read only if it really writes a nonzero register
    function automatic logic ent_hit(input ent_t e, input logic [4:0] ra);
        return (e.waddr == ra) && (ra != 5'd0) && (e.wren != 4'd0);
    endfunction

    // Write-port grant: the pipeline wins unless flushed or held by our own stall, else the FIFO head pops
    always_comb begin
        w_pipe     = '{wren: bus.wb_wren_i, waddr: bus.wb_waddr_i, wdata: bus.wb_wdata_i, pc: bus.wb_pc_i};
        w_in       = '{wren: bus.lr_wren_i, waddr: bus.lr_waddr_i, wdata: bus.lr_wdata_i, pc: bus.lr_pc_i};
        w_head     = r_mem[r_rd_ptr];
        w_pipe_req = (bus.wb_wren_i != 4'd0) && !bus.wb_flush_i && !r_stall;
        w_fifo_req = (r_count != '0);
        w_pop      = w_fifo_req && !w_pipe_req;
        w_ready    = (r_count < DEPTH_C) || w_pop;
        w_push     = bus.lr_valid_i && w_ready;
        w_grant    = '0;
        if (w_pipe_req) begin
            w_grant = w_pipe;
        end else if (w_fifo_req) begin
            w_grant = w_head;
        end
    end

    // Head age: restarts whenever the head changes or the queue is empty, saturates at the limit
    always_comb begin
        w_age_nxt = r_age;
        if (w_pop || !w_fifo_req) begin
            w_age_nxt = 4'd0;
        end else if (r_age < LIMIT_C) begin
            w_age_nxt = r_age + 4'd1;
        end
    end

    // Pending-write lookup over live entries, counting an incoming push and ignoring a departing head
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && !((i == 0) && w_pop)) begin
                w_hit1 = w_hit1 | ent_hit(r_mem[r_rd_ptr + PW'(i)], bus.id_raddr1_i);
                w_hit2 = w_hit2 | ent_hit(r_mem[r_rd_ptr + PW'(i)], bus.id_raddr2_i);
            end
        end
        if (w_push) begin
            w_hit1 = w_hit1 | ent_hit(w_in, bus.id_raddr1_i);
            w_hit2 = w_hit2 | ent_hit(w_in, bus.id_raddr2_i);
        end
    end

    // FIFO pointers/occupancy, head age and stall request; reset drops every queued result
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_age    <= 4'd0;
            r_stall  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_age <= w_age_nxt;
            // the stall suppresses the pipeline, so the head always pops in the stall cycle
            if (w_pop) begin
                r_stall <= 1'b0;
            end else if (w_age_nxt == LIMIT_C) begin
                r_stall <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are meaningful
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    assign bus.lr_ready_o        = w_ready;
    assign bus.pend_hit1_o       = w_hit1;
    assign bus.pend_hit2_o       = w_hit2;
    assign bus.wb_stallreq_o     = r_stall;
    assign bus.rf_wren_o         = w_grant.wren;
    assign bus.rf_waddr_o        = w_grant.waddr;
    assign bus.rf_wdata_o        = w_grant.wdata;
    assign bus.debug_wb_pc       = w_grant.pc;
    assign bus.debug_wb_rf_wen   = w_grant.wren;
    assign bus.debug_wb_rf_wnum  = w_grant.waddr;
    assign bus.debug_wb_rf_wdata = w_grant.wdata;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for the write-port arbiter with hand-computed expectations (DEPTH=2, STARVE_LIMIT=4).
// Inputs change 2 time units after the rising edge, outputs are sampled at the falling edge.
// Covers grant priority, FIFO drain, starvation stall, full FIFO, flush and mid-run reset.
module tb_rf_wport_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rf_wport_arbiter_if ifc ();

    rf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_wb(input logic fl, input logic [3:0] we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [31:0] pc);
        ifc.wb_flush_i = fl;
        ifc.wb_wren_i  = we;
        ifc.wb_waddr_i = wa;
        ifc.wb_wdata_i = wd;
        ifc.wb_pc_i    = pc;
    endtask

    task automatic set_lr(input logic v, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
        ifc.lr_valid_i = v;
        ifc.lr_wren_i  = 4'hF;
        ifc.lr_waddr_i = wa;
        ifc.lr_wdata_i = wd;
        ifc.lr_pc_i    = pc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        set_wb(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
        set_lr(1'b0, 5'd0, 32'h0, 32'h0);
        ifc.id_raddr1_i = 5'd0;
        ifc.id_raddr2_i = 5'd0;

        // reset state
        #3;
        chk("rst_wren",  32'(ifc.rf_wren_o), 32'h0);
        chk("rst_waddr", 32'(ifc.rf_waddr_o), 32'h0);
        chk("rst_dbgpc", ifc.debug_wb_pc, 32'h0);
        chk("rst_stall", 32'(ifc.wb_stallreq_o), 32'h0);
        chk("rst_ready", 32'(ifc.lr_ready_o), 32'h1);
        chk("rst_hit1",  32'(ifc.pend_hit1_o), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;

        // pipeline-only write passes straight through
        cyc(); set_wb(1'b0, 4'hF, 5'd3, 32'h11, 32'hBFC0_0000); settle();
        chk("p_wren",   32'(ifc.rf_wren_o), 32'hF);
        chk("p_waddr",  32'(ifc.rf_waddr_o), 32'd3);
        chk("p_wdata",  ifc.rf_wdata_o, 32'h11);
        chk("p_dbgpc",  ifc.debug_wb_pc, 32'hBFC0_0000);
        chk("p_dbgnum", 32'(ifc.debug_wb_rf_wnum), 32'd3);
        chk("p_dbgwen", 32'(ifc.debug_wb_rf_wen), 32'hF);
        cyc(); set_wb(1'b0, 4'h0, 5'd0, 32'h0, 32'h0); settle();
        chk("p_idle_wren", 32'(ifc.rf_wren_o), 32'h0);
        chk("p_idle_ready", 32'(ifc.lr_ready_o), 32'h1);

        // single result drained into an idle slot the cycle after push
        cyc(); set_lr(1'b1, 5'd5, 32'hAA, 32'h100); ifc.id_raddr1_i = 5'd5; settle();
        chk("lr_push_hit1", 32'(ifc.pend_hit1_o), 32'h1);
        chk("lr_push_wren", 32'(ifc.rf_wren_o), 32'h0);
        cyc(); set_lr(1'b0, 5'd0, 32'h0, 32'h0); settle();
        chk("lr_pop_waddr", 32'(ifc.rf_waddr_o), 32'd5);
        chk("lr_pop_wdata", ifc.rf_wdata_o, 32'hAA);
        chk("lr_pop_dbgpc", ifc.debug_wb_pc, 32'h100);
        chk("lr_pop_hit1",  32'(ifc.pend_hit1_o), 32'h0);
        cyc(); settle();
        chk("lr_after_wren", 32'(ifc.rf_wren_o), 32'h0);
        chk("lr_after_hit1", 32'(ifc.pend_hit1_o), 32'h0);

        // starvation: pipeline busy every cycle, stall appears 4 edges after the push
        cyc(); set_wb(1'b0, 4'hF, 5'd7, 32'h77, 32'h300); set_lr(1'b1, 5'd5, 32'h55, 32'h104); settle();
        chk("st_c0_waddr", 32'(ifc.rf_waddr_o), 32'd7);
        for (int i = 1; i <= 4; i++) begin
            cyc(); set_lr(1'b0, 5'd0, 32'h0, 32'h0); settle();
            chk($sformatf("st_c%0d_stall", i), 32'(ifc.wb_stallreq_o), 32'h0);
            chk($sformatf("st_c%0d_waddr", i), 32'(ifc.rf_waddr_o), 32'd7);
            chk($sformatf("st_c%0d_hit1", i), 32'(ifc.pend_hit1_o), 32'h1);
        end
        cyc(); settle();
        chk("st_stall",  32'(ifc.wb_stallreq_o), 32'h1);
        chk("st_waddr",  32'(ifc.rf_waddr_o), 32'd5);
        chk("st_wdata",  ifc.rf_wdata_o, 32'h55);
        chk("st_dbgpc",  ifc.debug_wb_pc, 32'h104);
        cyc(); settle();
        chk("st_rel_stall", 32'(ifc.wb_stallreq_o), 32'h0);
        chk("st_rel_waddr", 32'(ifc.rf_waddr_o), 32'd7);
        chk("st_rel_wdata", ifc.rf_wdata_o, 32'h77);

        // full FIFO: refuse, then accept in the same cycle as a pop
        cyc(); set_lr(1'b1, 5'd8, 32'h81, 32'h110); settle();
        chk("full_a_ready", 32'(ifc.lr_ready_o), 32'h1);
        cyc(); set_lr(1'b1, 5'd9, 32'h92, 32'h114); settle();
        chk("full_b_ready", 32'(ifc.lr_ready_o), 32'h1);
        cyc(); set_lr(1'b1, 5'd10, 32'hA3, 32'h118); ifc.id_raddr2_i = 5'd9; settle();
        chk("full_c_ready", 32'(ifc.lr_ready_o), 32'h0);
        chk("full_hit2",    32'(ifc.pend_hit2_o), 32'h1);
        chk("full_c_waddr", 32'(ifc.rf_waddr_o), 32'd7);
        cyc(); set_wb(1'b0, 4'h0, 5'd0, 32'h0, 32'h0); settle();
        chk("full_pop_waddr", 32'(ifc.rf_waddr_o), 32'd8);
        chk("full_pop_wdata", ifc.rf_wdata_o, 32'h81);
        chk("full_pop_ready", 32'(ifc.lr_ready_o), 32'h1);
        cyc(); set_wb(1'b0, 4'hF, 5'd7, 32'h77, 32'h300); set_lr(1'b1, 5'd11, 32'hB4, 32'h11C); settle();
        chk("full_still_ready", 32'(ifc.lr_ready_o), 32'h0);
        chk("full_still_hit2",  32'(ifc.pend_hit2_o), 32'h1);
        cyc(); set_wb(1'b0, 4'h0, 5'd0, 32'h0, 32'h0); set_lr(1'b0, 5'd0, 32'h0, 32'h0); settle();
        chk("full_b_waddr", 32'(ifc.rf_waddr_o), 32'd9);
        chk("full_b_wdata", ifc.rf_wdata_o, 32'h92);
        chk("full_b_hit2",  32'(ifc.pend_hit2_o), 32'h0);
        cyc(); settle();
        chk("full_cpop_waddr", 32'(ifc.rf_waddr_o), 32'd10);
        chk("full_cpop_wdata", ifc.rf_wdata_o, 32'hA3);
        cyc(); settle();
        chk("full_empty_wren", 32'(ifc.rf_wren_o), 32'h0);

        // flushed pipeline slot yields to the pending result
        cyc(); set_lr(1'b1, 5'd12, 32'hC0C0, 32'h200); ifc.id_raddr2_i = 5'd0; settle();
        chk("fl_push_wren", 32'(ifc.rf_wren_o), 32'h0);
        cyc(); set_lr(1'b0, 5'd0, 32'h0, 32'h0); set_wb(1'b1, 4'hF, 5'd3, 32'h33, 32'h400); settle();
        chk("fl_waddr", 32'(ifc.rf_waddr_o), 32'd12);
        chk("fl_wdata", ifc.rf_wdata_o, 32'hC0C0);
        chk("fl_dbgpc", ifc.debug_wb_pc, 32'h200);
        cyc(); set_wb(1'b0, 4'h0, 5'd0, 32'h0, 32'h0); settle();
        chk("fl_after_wren", 32'(ifc.rf_wren_o), 32'h0);

        // asynchronous reset with two results queued
        cyc(); set_wb(1'b0, 4'hF, 5'd7, 32'h77, 32'h300); set_lr(1'b1, 5'd13, 32'hD1, 32'h210);
        ifc.id_raddr1_i = 5'd13; settle();
        chk("ar_a_ready", 32'(ifc.lr_ready_o), 32'h1);
        cyc(); set_lr(1'b1, 5'd14, 32'hE2, 32'h214); settle();
        chk("ar_b_ready", 32'(ifc.lr_ready_o), 32'h1);
        cyc(); set_lr(1'b0, 5'd0, 32'h0, 32'h0); settle();
        chk("ar_pend_hit1", 32'(ifc.pend_hit1_o), 32'h1);
        chk("ar_full_ready", 32'(ifc.lr_ready_o), 32'h0);
        #1; set_wb(1'b0, 4'h0, 5'd0, 32'h0, 32'h0); rst_n = 1'b1;
        #1;
        chk("ar_wren",  32'(ifc.rf_wren_o), 32'h0);
        chk("ar_wdata", ifc.rf_wdata_o, 32'h0);
        chk("ar_ready", 32'(ifc.lr_ready_o), 32'h1);
        chk("ar_hit1",  32'(ifc.pend_hit1_o), 32'h0);
        chk("ar_stall", 32'(ifc.wb_stallreq_o), 32'h0);
        cyc(); rst_n = 1'b0; settle();
        chk("ar_rel_wren",  32'(ifc.rf_wren_o), 32'h0);
        chk("ar_rel_ready", 32'(ifc.lr_ready_o), 32'h1);
        cyc(); settle();
        chk("ar_rel2_wren", 32'(ifc.rf_wren_o), 32'h0);
        chk("ar_rel2_hit1", 32'(ifc.pend_hit1_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
